double_tokens: RTL and testbench
================================

# double_tokens

Token multiplier on a single-bit token stream. Each input token, a one-cycle high pulse on `a`, produces exactly two output tokens on `b`. Output tokens come out one per cycle, and the block buffers any backlog in a saturating pending counter. It sits on the same pulse-stream fabric as the token-halving stage and forms the inverse rate conversion: a halver followed by a doubler preserves the token count, absent overflow.

## Interface
- `MAX_PENDING`, default 200: maximum number of tokens held in the backlog; must be ≥ 2.
- `CNT_W`, default `$clog2(MAX_PENDING+1)`: width of the pending counter; derived, not overridden.

Ports:
- `clk` — input, 1: clock, rising-edge active.
- `rst` — input, 1: synchronous, active-high reset.
- `a` — input, 1: input token; each high cycle is one token.
- `b` — output, 1: output token; each high cycle is one token.
- `pending` — output, `CNT_W`: tokens owed but not yet emitted (registered count).
- `overflow` — output, 1: sticky flag; set when a token is dropped because the backlog is full.

## Operation
- State:
  - `cnt`, a `CNT_W`-bit register, range 0..`MAX_PENDING`.
  - `ovf`, a 1-bit sticky register.
- `b` is combinational: `b = !rst & (a | (cnt != 0))`.
  - An arriving token emits its first output token in the same cycle.
- Counter update per cycle when `rst`=0, using unsigned math at `CNT_W+2` bits:
  - `sum = cnt + (a ? 2 : 0) - (b ? 1 : 0)`.
  - If `sum` ≤ `MAX_PENDING`: `cnt <= sum`.
  - Else: `cnt <= MAX_PENDING` and `ovf <= 1`. The excess tokens are lost; at most one is lost per cycle.
- `ovf` clears only on `rst`. It has no effect on token flow: the block keeps doubling after an overflow.
- Cycle cases:
  - `a`=1, `cnt`=0: `b`=1, `cnt` goes to 1.
  - `a`=1, `cnt`>0: `b`=1, net +1.
  - `a`=0, `cnt`>0: `b`=1, net −1.
  - `a`=0, `cnt`=0: `b`=0, idle.
- Continuous `a`=1 grows the backlog by 1 per cycle. The backlog reaches `MAX_PENDING`, and overflow sets on the first cycle `sum` would be `MAX_PENDING`+1.
- Output assignments:
  - `pending = cnt`.
  - `overflow = ovf`.

## Timing
- Reset values, with `rst`=1 sampled at a rising edge:
  - `cnt` = 0, `ovf` = 0, `pending` = 0, `overflow` = 0.
  - `b` is forced to 0 for every cycle `rst` is high, regardless of `a`.
- Tokens arriving while `rst`=1 are discarded, not counted.
- Reset mid-backlog drops all owed tokens. `b`=0 from the first cycle `rst` is high, and the first post-reset cycle with `a`=0 gives `b`=0.
- Latency:
  - First output token: 0 cycles, combinational from `a`.
  - Second output token: the next cycle with no competing backlog.
- Throughput: at most 1 output token per cycle. Sustainable input rate is ≤ 1 token per 2 cycles; anything higher grows the backlog.
- Conservation: with no reset and `overflow`=0, total `b` pulses = 2 × total `a` pulses − `pending`, at every cycle boundary.
- `pending` and `overflow` change only on rising edges. `b` may change within a cycle following `a`; no glitch requirement applies beyond synchronous sampling.

## Test plan
- Single token: reset, then `a`=1 for 1 cycle, then 0. Required: `b`=1 on cycles 0 and 1, `b`=0 after; `pending` goes 1 then 0.
- Alternating input: `a` = 1,0,1,0 for 20 cycles. Required: `b`=1 every cycle from the first token; `pending` toggles 1/0; total `b` = 20 after the drain.
- Burst: `a`=1 for 5 consecutive cycles. Required: `pending` = 1,2,3,4,5 after each edge. Then with `a`=0, `b` stays high for 5 more cycles; total `b` = 10; `overflow`=0.
- Overflow: `MAX_PENDING`=4, `a`=1 for 6 cycles. Required: `pending` saturates at 4 on the 4th edge; `overflow`=1 from the 5th edge and stays 1 through the drain; the drain yields exactly 4 further `b` pulses.
- Reset mid-backlog: burst of 3 tokens, then `rst`=1 for 1 cycle with `a`=1. Required: `b`=0 during the reset cycle; after it `pending`=0 and `overflow`=0, and `b`=0 while `a`=0.
- Random stimulus with `MAX_PENDING`=200 and input density ≤ 50%, 10k cycles. Required: the conservation equation holds every cycle and `overflow` never sets.

Source files
------------

// File: rtl/double_tokens_if.sv
// Token stream bundle for double_tokens: input token, output token and backlog status.
// CNT_W must match the width the attached double_tokens derives from its MAX_PENDING.
interface double_tokens_if #(
   parameter int CNT_W = 8
);
   logic             a;
   logic             b;
   logic [CNT_W-1:0] pending;
   logic             overflow;

   modport master (
      output a,
      input  b,
      input  pending,
      input  overflow
   );

   modport slave (
      input  a,
      output b,
      output pending,
      output overflow
   );
endinterface

// File: rtl/double_tokens.sv
// Token doubler: every input pulse on a yields two pulses on b, one per cycle,
// with the owed tokens held in a saturating backlog counter and a sticky drop flag.
module double_tokens #(
   parameter int MAX_PENDING = 200,
   parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          rst,
   double_tokens_if.slave tok
);

   // Headroom of two bits so cnt + 2 - 1 never wraps before the saturation test.
   localparam logic [CNT_W+1:0] MAX_WIDE_C = (CNT_W + 2)'(MAX_PENDING);
   localparam logic [CNT_W+1:0] TWO_C      = (CNT_W + 2)'(2);
   localparam logic [CNT_W+1:0] ONE_C      = (CNT_W + 2)'(1);
   localparam logic [CNT_W+1:0] ZERO_C     = (CNT_W + 2)'(0);
   localparam logic [CNT_W-1:0] MAX_CNT_C  = CNT_W'(MAX_PENDING);

   logic [CNT_W-1:0] cnt_r;
   logic             ovf_r;
   logic             b_s;
   logic             busy_s;
   logic [CNT_W+1:0] add_s;
   logic [CNT_W+1:0] sub_s;
   logic [CNT_W+1:0] sum_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_nxt_s;

   // Output token and next backlog value; the first copy of a token leaves in its arrival cycle.
   always_comb begin
      busy_s    = (cnt_r != {CNT_W{1'b0}});
      b_s       = ~rst & (tok.a | busy_s);
      add_s     = ZERO_C;
      sub_s     = ZERO_C;
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_r;

      if (tok.a) begin
         add_s = TWO_C;
      end else begin
         add_s = ZERO_C;
      end

      if (b_s) begin
         sub_s = ONE_C;
      end else begin
         sub_s = ZERO_C;
      end

      sum_s = {2'b00, cnt_r} + add_s - sub_s;

      // A full backlog drops the excess token but keeps doubling afterwards.
      if (sum_s > MAX_WIDE_C) begin
         cnt_nxt_s = MAX_CNT_C;
         ovf_nxt_s = 1'b1;
      end else begin
         cnt_nxt_s = sum_s[CNT_W-1:0];
         ovf_nxt_s = ovf_r;
      end
   end

   // Backlog counter and sticky overflow register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         ovf_r <= ovf_nxt_s;
      end
   end

   assign tok.b        = b_s;
   assign tok.pending  = cnt_r;
   assign tok.overflow = ovf_r;

endmodule

// File: tb/tb_double_tokens.sv
// Directed and random checks of double_tokens: a 200-deep instance for the main
// behaviour and a 4-deep instance for saturation and the sticky overflow flag.
module tb_double_tokens;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   int   n_printed;
   logic b0_smp;
   logic b1_smp;

   double_tokens_if #(.CNT_W(8)) if0 ();
   double_tokens_if #(.CNT_W(3)) if1 ();

   double_tokens #(.MAX_PENDING(200)) dut0 (.clk(clk), .rst(rst), .tok(if0.slave));
   double_tokens #(.MAX_PENDING(4))   dut1 (.clk(clk), .rst(rst), .tok(if1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string name;
      logic  rst;
      logic  a;
      logic  exp_b;
      int    exp_pend;
      logic  exp_ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_printed < 40) begin
            n_printed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
         end
      end
   endtask

   // One clock cycle: drive just after the rising edge, sample b at the falling
   // edge, then return 1 time unit after the next rising edge.
   task automatic cyc(input logic rv, input logic av0, input logic av1);
      rst  = rv;
      if0.a = av0;
      if1.a = av1;
      @(negedge clk);
      b0_smp = if0.b;
      b1_smp = if1.b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tot_a;
      int tot_b;
      int cnt_b;
      n_cmp     = 0;
      n_fail    = 0;
      n_printed = 0;
      rst   = 1'b1;
      if0.a = 1'b0;
      if1.a = 1'b0;
      @(posedge clk);
      #1;

      // reset, with a token offered during reset
      tbl.push_back('{"rst_a1",   1'b1, 1'b1, 1'b0, 0, 1'b0});
      tbl.push_back('{"rst_a0",   1'b1, 1'b0, 1'b0, 0, 1'b0});
      tbl.push_back('{"idle",     1'b0, 1'b0, 1'b0, 0, 1'b0});
      // single token
      tbl.push_back('{"single0",  1'b0, 1'b1, 1'b1, 1, 1'b0});
      tbl.push_back('{"single1",  1'b0, 1'b0, 1'b1, 0, 1'b0});
      tbl.push_back('{"single2",  1'b0, 1'b0, 1'b0, 0, 1'b0});
      // burst of 5 then drain
      tbl.push_back('{"burst1",   1'b0, 1'b1, 1'b1, 1, 1'b0});
      tbl.push_back('{"burst2",   1'b0, 1'b1, 1'b1, 2, 1'b0});
      tbl.push_back('{"burst3",   1'b0, 1'b1, 1'b1, 3, 1'b0});
      tbl.push_back('{"burst4",   1'b0, 1'b1, 1'b1, 4, 1'b0});
      tbl.push_back('{"burst5",   1'b0, 1'b1, 1'b1, 5, 1'b0});
      tbl.push_back('{"drain4",   1'b0, 1'b0, 1'b1, 4, 1'b0});
      tbl.push_back('{"drain3",   1'b0, 1'b0, 1'b1, 3, 1'b0});
      tbl.push_back('{"drain2",   1'b0, 1'b0, 1'b1, 2, 1'b0});
      tbl.push_back('{"drain1",   1'b0, 1'b0, 1'b1, 1, 1'b0});
      tbl.push_back('{"drain0",   1'b0, 1'b0, 1'b1, 0, 1'b0});
      tbl.push_back('{"drained",  1'b0, 1'b0, 1'b0, 0, 1'b0});
      // mixed arrivals with a backlog present
      tbl.push_back('{"mix1",     1'b0, 1'b1, 1'b1, 1, 1'b0});
      tbl.push_back('{"mix2",     1'b0, 1'b1, 1'b1, 2, 1'b0});
      tbl.push_back('{"mix3",     1'b0, 1'b0, 1'b1, 1, 1'b0});
      tbl.push_back('{"mix4",     1'b0, 1'b1, 1'b1, 2, 1'b0});
      tbl.push_back('{"mix5",     1'b0, 1'b0, 1'b1, 1, 1'b0});
      tbl.push_back('{"mix6",     1'b0, 1'b0, 1'b1, 0, 1'b0});
      tbl.push_back('{"mix7",     1'b0, 1'b0, 1'b0, 0, 1'b0});
      // reset in the middle of a backlog
      tbl.push_back('{"mid1",     1'b0, 1'b1, 1'b1, 1, 1'b0});
      tbl.push_back('{"mid2",     1'b0, 1'b1, 1'b1, 2, 1'b0});
      tbl.push_back('{"mid3",     1'b0, 1'b1, 1'b1, 3, 1'b0});
      tbl.push_back('{"mid_rst",  1'b1, 1'b1, 1'b0, 0, 1'b0});
      tbl.push_back('{"post1",    1'b0, 1'b0, 1'b0, 0, 1'b0});
      tbl.push_back('{"post2",    1'b0, 1'b0, 1'b0, 0, 1'b0});

      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].a, 1'b0);
         chk({tbl[i].name, "_b"},    int'(b0_smp),        int'(tbl[i].exp_b));
         chk({tbl[i].name, "_pend"}, int'(if0.pending),   tbl[i].exp_pend);
         chk({tbl[i].name, "_ovf"},  int'(if0.overflow),  int'(tbl[i].exp_ovf));
      end

      // alternating input for 20 cycles, then drain
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, (i % 2 == 0), 1'b0);
         cnt_b += int'(b0_smp);
         chk("alt_b", int'(b0_smp), 1);
         chk("alt_pend", int'(if0.pending), (i % 2 == 0) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         cnt_b += int'(b0_smp);
      end
      chk("alt_total_b", cnt_b, 20);

      // saturation on the 4-deep instance: 6 back-to-back tokens
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         chk("ovf_b", int'(b1_smp), 1);
         chk("ovf_pend", int'(if1.pending), (i < 4) ? i + 1 : 4);
         chk("ovf_flag", int'(if1.overflow), (i >= 4) ? 1 : 0);
      end
      cnt_b = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         cnt_b += int'(b1_smp);
         chk("ovf_drain_flag", int'(if1.overflow), 1);
      end
      chk("ovf_drain_b", cnt_b, 4);
      chk("ovf_drain_pend", int'(if1.pending), 0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("ovf_rst_flag", int'(if1.overflow), 0);

      // random stimulus at about one token in three, conservation every cycle
      tot_a = 0;
      tot_b = 0;
      for (int i = 0; i < 10000; i++) begin
         logic av;
         av = ($urandom_range(0, 2) == 0);
         cyc(1'b0, av, 1'b0);
         tot_a += int'(av);
         tot_b += int'(b0_smp);
         chk("rnd_conserve", tot_b, 2 * tot_a - int'(if0.pending));
      end
      chk("rnd_ovf", int'(if0.overflow), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
